// File: rtl/instr_fetch_queue.sv
// Fetch stage in front of the instruction memory. It owns the PC, issues IM reads
// and queues the returned words in a 2-entry buffer for decode.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OP   = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  input  logic [15:0]       im_instr,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [15:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_inc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted
);

  // state | meaning
  // RUN   | fetching from pc_q
  // HALT  | HLT pushed; no further fetches until reset
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              reset_first_q, reset_first_d;
  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic [15:0]       ent_instr_q [2];
  logic [15:0]       ent_instr_d [2];
  logic [ADDR_W-1:0] ent_pc_q    [2];
  logic [ADDR_W-1:0] ent_pc_d    [2];
  logic [ADDR_W-1:0] ent_inc_q   [2];
  logic [ADDR_W-1:0] ent_inc_d   [2];

  logic fetch_ok;
  logic push;
  logic pop;
  logic wr_idx;
  logic hlt_push;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hlt_push) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fetch_ok = 1'b0;
    halted   = 1'b0;
    case (state_q)
      RUN:     fetch_ok = 1'b1;
      HALT:    halted   = 1'b1;
      default: fetch_ok = 1'b0;
    endcase
  end

  assign id_valid  = (count_q != 2'd0);
  assign pop       = id_valid & id_ready;
  assign im_rd_en  = fetch_ok & ~br_taken & ~reset_first_q & ((count_q < 2'd2) | pop);
  assign push      = im_rd_en;
  assign hlt_push  = push & (im_instr[15:12] == HLT_OP);
  // Tail slot is head+count mod 2; with count==2 and a pop it is the slot being freed.
  assign wr_idx    = head_q ^ count_q[0];
  assign im_addr   = pc_q;
  assign id_instr  = ent_instr_q[head_q];
  assign id_pc     = ent_pc_q[head_q];
  assign id_pc_inc = ent_inc_q[head_q];

  always_comb begin
    pc_d          = pc_q;
    reset_first_d = 1'b0;
    count_d       = count_q;
    head_d        = head_q;
    ent_instr_d   = ent_instr_q;
    ent_pc_d      = ent_pc_q;
    ent_inc_d     = ent_inc_q;
    if (br_taken) begin
      pc_d    = br_target;
      count_d = 2'd0;
    end else begin
      if (push) begin
        ent_instr_d[wr_idx] = im_instr;
        ent_pc_d[wr_idx]    = pc_q;
        ent_inc_d[wr_idx]   = pc_q + PC_ONE;
        pc_d                = pc_q + PC_ONE;
      end
      if (pop) head_d = ~head_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      reset_first_q <= 1'b1;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_instr_q[i] <= '0;
        ent_pc_q[i]    <= '0;
        ent_inc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      reset_first_q <= reset_first_d;
      count_q       <= count_d;
      head_q        <= head_d;
      ent_instr_q   <= ent_instr_d;
      ent_pc_q      <= ent_pc_d;
      ent_inc_q     <= ent_inc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a behavioural negedge-read IM model.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [10:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [10:0] id_pc;
  logic [10:0] id_pc_inc;
  logic        br_taken;
  logic [10:0] br_target;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [0:2047];

  instr_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd_en(im_rd_en),
    .im_instr(im_instr), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_inc(id_pc_inc),
    .br_taken(br_taken), .br_target(br_target), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (im_rd_en) im_instr <= mem[im_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first cycle after release).
  task automatic do_reset(input bit chk_rst);
    rst_n = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    step();
    if (chk_rst) begin
      check("rst_valid",  id_valid,  0);
      check("rst_instr",  id_instr,  0);
      check("rst_pc",     id_pc,     0);
      check("rst_pc_inc", id_pc_inc, 0);
      check("rst_halted", halted,    0);
      check("rst_rd_en",  im_rd_en,  0);
      check("rst_addr",   im_addr,   0);
    end
    rst_n = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] ins, input logic [10:0] pc,
                          input logic [10:0] inc);
    check({tag, "_valid"}, id_valid,  1);
    check({tag, "_instr"}, id_instr,  ins);
    check({tag, "_pc"},    id_pc,     pc);
    check({tag, "_inc"},   id_pc_inc, inc);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'h1004;
    mem[4] = 16'h1005; mem[5] = 16'hF000; mem[6] = 16'h1006;
    mem[11'h100] = 16'h2100; mem[11'h101] = 16'h2101;
    mem[11'h7FE] = 16'h37FE; mem[11'h7FF] = 16'h37FF;
    im_instr = '0;

    // Streaming with id_ready=1, ending in HLT at address 5
    do_reset(1);
    #1 check("a_c0_rd_en", im_rd_en, 0);
    id_ready = 1'b1;
    step(); #1;
    check("a_c1_rd_en", im_rd_en, 1);
    check("a_c1_valid", id_valid, 0);
    step(); chk_head("a_c2", 16'h1001, 11'd0, 11'd1);
    step(); chk_head("a_c3", 16'h1002, 11'd1, 11'd2);
    step(); chk_head("a_c4", 16'h1003, 11'd2, 11'd3);
    step(); step(); step();
    chk_head("a_hlt", 16'hF000, 11'd5, 11'd6);
    check("a_halted", halted, 1);
    #1 check("a_hlt_rd_en", im_rd_en, 0);
    step();
    check("a_c8_valid", id_valid, 0);
    check("a_c8_addr", im_addr, 11'd6);
    br_taken = 1'b1; br_target = 11'h100;
    step(); br_taken = 1'b0;
    check("a_hbr_halted", halted, 1);
    check("a_hbr_addr", im_addr, 11'h100);
    check("a_hbr_valid", id_valid, 0);
    #1 check("a_hbr_rd_en", im_rd_en, 0);
    step();
    check("a_c10_valid", id_valid, 0);

    // Branch racing the HLT fetch: no push, no halt
    do_reset(0);
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk_head("g_c6", 16'h1005, 11'd4, 11'd5);
    br_taken = 1'b1; br_target = 11'h100;
    step(); br_taken = 1'b0;
    check("g_halted", halted, 0);
    check("g_valid", id_valid, 0);
    check("g_addr", im_addr, 11'h100);
    #1 check("g_rd_en", im_rd_en, 1);
    step(); chk_head("g_tgt", 16'h2100, 11'h100, 11'h101);

    // Stall with full queue, then release
    do_reset(0);
    step(); step();
    chk_head("b_c2", 16'h1001, 11'd0, 11'd1);
    check("b_c2_addr", im_addr, 11'd1);
    #1 check("b_c2_rd_en", im_rd_en, 1);
    for (int i = 3; i <= 5; i++) begin
      step();
      check($sformatf("b_c%0d_addr", i), im_addr, 11'd2);
      check($sformatf("b_c%0d_instr", i), id_instr, 16'h1001);
      #1 check($sformatf("b_c%0d_rd_en", i), im_rd_en, 0);
    end
    step();
    chk_head("b_r0", 16'h1001, 11'd0, 11'd1);
    id_ready = 1'b1;
    #1 check("b_r0_rd_en", im_rd_en, 1);
    step(); chk_head("b_r1", 16'h1002, 11'd1, 11'd2);
    step(); chk_head("b_r2", 16'h1003, 11'd2, 11'd3);
    step(); chk_head("b_r3", 16'h1004, 11'd3, 11'd4);

    // Branch with full queue, then branch to the wrap boundary
    do_reset(0);
    step(); step(); step(); step();
    br_taken = 1'b1; br_target = 11'h100;
    #1 check("c_br_rd_en", im_rd_en, 0);
    step(); br_taken = 1'b0;
    check("c_flush_valid", id_valid, 0);
    check("c_flush_addr", im_addr, 11'h100);
    step(); chk_head("c_tgt", 16'h2100, 11'h100, 11'h101);
    id_ready = 1'b1; br_taken = 1'b1; br_target = 11'h7FE;
    step(); br_taken = 1'b0;
    check("d_flush_valid", id_valid, 0);
    step(); chk_head("d_7fe", 16'h37FE, 11'h7FE, 11'h7FF);
    step(); chk_head("d_7ff", 16'h37FF, 11'h7FF, 11'h000);
    step(); chk_head("d_000", 16'h1001, 11'h000, 11'h001);

    // Async reset in the middle of a full-queue stall
    do_reset(0);
    step(); step(); step();
    check("f_pre_addr", im_addr, 11'd2);
    #2 rst_n = 1'b0;
    #1;
    check("f_async_valid", id_valid, 0);
    check("f_async_addr", im_addr, 11'd0);
    check("f_async_rd_en", im_rd_en, 0);
    step();
    rst_n = 1'b1; id_ready = 1'b1;
    #1 check("f_c0_rd_en", im_rd_en, 0);
    step(); #1;
    check("f_c1_rd_en", im_rd_en, 1);
    check("f_c1_addr", im_addr, 11'd0);
    step(); chk_head("f_c2", 16'h1001, 11'd0, 11'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the 2048x16 instruction memory (IM).
- Owns the PC and drives the IM address and read-enable.
- Captures each returned instruction into a 2-entry queue and presents it to decode with a valid/ready handshake.
- Handles branch redirect/flush from execute and stops fetching after a HLT.

Parameters:
- ADDR_W, 11, IM word-address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
- clk  in  1  system clock; IM reads on negedge, this block updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- im_addr  out  ADDR_W  IM read address; equals the pc register.
- im_rd_en  out  1  IM read enable (combinational, see issue rule).
- im_instr  in  16  IM read data; valid from negedge of the issuing cycle.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  16  instruction at queue head.
- id_pc  out  ADDR_W  address of id_instr.
- id_pc_inc  out  ADDR_W  id_pc+1, wrapping.
- br_taken  in  1  redirect request from execute, one-cycle pulse.
- br_target  in  ADDR_W  redirect address.
- halted  out  1  fetch stopped by HLT.

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC; queue empty, count=0; state=RUN.
  - Outputs: id_valid=0, id_instr=0, id_pc=0, id_pc_inc=0, halted=0, im_rd_en=0.
- States:
  - RUN: fetching.
  - HALT: no fetches; halted=1.
- Transitions:
  - RUN->HALT when an issued word with instr[15:12]==HLT_OP is pushed and br_taken=0.
  - HALT->RUN only on reset; br_taken in HALT still flushes the queue and loads pc, but the block stays in HALT.
- Handshake:
  - pop = id_valid & id_ready.
  - id_valid = (count!=0).
  - id_instr/id_pc come from the head entry.
- Issue rule: im_rd_en = (state==RUN) & ~br_taken & ~reset_first & (count<2 | pop).
  - reset_first is 1 only in the first cycle after rst_n deasserts. This gives IM one negedge before the first read.
- Latency:
  - Word addressed in cycle n is pushed at the posedge ending cycle n, with its pc, and pc<=pc+1.
  - It is visible on id_* in cycle n+1 if the queue was empty.
  - Fetch-to-decode latency is 1 cycle; throughput is 1 instruction/cycle while id_ready=1.
- Queue: 2 entries, circular.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push never occurs when count==2 without a pop.
  - Pop when empty is ignored.
- Full/stall: count==2 and id_ready=0 -> im_rd_en=0; pc, queue and IM output all hold.
- Branch: br_taken=1 in cycle n.
  - At the posedge: queue cleared (count=0), pc<=br_target; no push occurs because im_rd_en=0.
  - A pop in the same cycle is still counted as consumed by decode.
  - First target instruction appears on id_* in cycle n+2.
  - Branch beats a simultaneous HLT push (no push, so no halt).
- Wrap: pc 2^ADDR_W-1 increments to 0; id_pc_inc of 2047 is 0.
- No X propagation: the data fields of empty entries keep their last value, but id_valid=0.

Test Plan:
- Reset then id_ready=1, IM holding 0x1001,0x1002,0x1003 at 0..2 -> id_valid first high in cycle 2 after reset; id_instr sequence 0x1001,0x1002,0x1003 with id_pc 0,1,2 on consecutive cycles.
- id_ready=0 for 4 cycles after the first valid -> count reaches 2; im_rd_en=0; im_addr frozen at 2. Release -> 0x1001,0x1002,0x1003 delivered in order with no loss or duplicate.
- br_taken=1, br_target=0x100 while the queue holds 2 entries -> id_valid=0 next cycle; instr[0x100] with id_pc=0x100 on id_* two cycles after the pulse.
- HLT (0xF000) at address 5 -> delivered with id_pc=5; halted=1; im_rd_en stays 0; no address-6 instruction ever appears.
- br_taken to 0x7FE, with words at 0x7FE, 0x7FF, 0x000 -> id_pc sequence 0x7FE, 0x7FF, 0x000; id_pc_inc of 0x7FF is 0x000.
- rst_n pulsed low mid-stall with count=2 -> id_valid=0 and im_addr=0 immediately (async); fetch restarts from 0 after release.
